firefly_queen: RTL and testbench



---
 rtl/firefly_queen.sv | 152 +++++++++++++++
 tb/tb_firefly_queen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/firefly_queen.sv
// ============================================================================
// Module   : firefly_queen
// Brief    : Periodic queen flash generator with per-period response checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module firefly_queen #(
    parameter int PERIOD  = 50000,
    parameter int FLASH_W = 1000,
    parameter int RESP_W  = 15001,
    parameter int TOL     = 2,
    parameter int MAX_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        f1,
    output logic        f0,
    output logic        resp_ok,
    output logic        resp_err,
    output logic [7:0]  pulse_cnt,
    output logic [15:0] last_lat,
    output logic [15:0] last_width
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_FLASH = 2'd1;
    localparam logic [1:0] c_S_GAP   = 2'd2;

    localparam logic [15:0] c_FLASH_END  = 16'(FLASH_W - 1);
    localparam logic [15:0] c_PERIOD_END = 16'(PERIOD - 1);
    localparam logic [15:0] c_MAX_LAT    = (MAX_LAT > 65535) ? 16'hFFFF : 16'(MAX_LAT);
    localparam int          c_W_LO       = RESP_W - TOL;
    localparam int          c_W_HI       = RESP_W + TOL;
    localparam logic [15:0] c_NO_LAT     = 16'hFFFF;

    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_lat;
    logic [15:0] r_width;
    logic [1:0]  r_rises;
    logic        r_prev;
    logic        r_start_hi;

    logic        w_first;
    logic [15:0] w_lat_b;
    logic [15:0] w_width_b;
    logic [1:0]  w_rises_b;
    logic        w_prev_b;
    logic [15:0] w_lat_n;
    logic [15:0] w_width_n;
    logic [1:0]  w_rises_n;
    logic        w_start_hi_n;
    logic        w_width_ok;
    logic        w_pass;

    // Monitor next-state: at cnt=0 the per-period registers are treated as
    // already cleared so the first sample of the period is folded in directly.
    always_comb begin
        w_first      = (r_cnt == 16'd0);
        w_lat_b      = w_first ? c_NO_LAT : r_lat;
        w_width_b    = w_first ? 16'd0    : r_width;
        w_rises_b    = w_first ? 2'd0     : r_rises;
        w_prev_b     = w_first ? 1'b0     : r_prev;
        w_start_hi_n = w_first ? f1       : r_start_hi;

        w_lat_n   = (f1 && (w_lat_b == c_NO_LAT)) ? r_cnt : w_lat_b;
        w_width_n = (f1 && (w_width_b != 16'hFFFF)) ? w_width_b + 16'd1 : w_width_b;
        w_rises_n = (f1 && !w_prev_b && (w_rises_b != 2'd3)) ? w_rises_b + 2'd1 : w_rises_b;

        w_width_ok = ($signed({16'd0, w_width_n}) >= c_W_LO) &&
                     ($signed({16'd0, w_width_n}) <= c_W_HI);
        w_pass     = (w_rises_n == 2'd1) && !w_start_hi_n &&
                     (w_lat_n <= c_MAX_LAT) && w_width_ok && !f1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_cnt      <= 16'd0;
            f0         <= 1'b0;
            resp_ok    <= 1'b0;
            resp_err   <= 1'b0;
            pulse_cnt  <= 8'd0;
            last_lat   <= c_NO_LAT;
            last_width <= 16'd0;
            r_lat      <= c_NO_LAT;
            r_width    <= 16'd0;
            r_rises    <= 2'd0;
            r_prev     <= 1'b0;
            r_start_hi <= 1'b0;
        end else begin
            resp_ok  <= 1'b0;
            resp_err <= 1'b0;

            if (r_state != c_S_IDLE) begin
                r_lat      <= w_lat_n;
                r_width    <= w_width_n;
                r_rises    <= w_rises_n;
                r_prev     <= f1;
                r_start_hi <= w_start_hi_n;
            end

            case (r_state)
                c_S_IDLE: begin
                    r_cnt <= 16'd0;
                    if (en) begin
                        r_state   <= c_S_FLASH;
                        f0        <= 1'b1;
                        pulse_cnt <= pulse_cnt + 8'd1;
                    end
                end
                c_S_FLASH: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (r_cnt == c_FLASH_END) begin
                        r_state <= c_S_GAP;
                        f0      <= 1'b0;
                    end
                end
                c_S_GAP: begin
                    if (r_cnt == c_PERIOD_END) begin
                        resp_ok    <= w_pass;
                        resp_err   <= !w_pass;
                        last_lat   <= w_lat_n;
                        last_width <= w_width_n;
                        r_cnt      <= 16'd0;
                        // en is only honoured here, at the period boundary
                        if (en) begin
                            r_state   <= c_S_FLASH;
                            f0        <= 1'b1;
                            pulse_cnt <= pulse_cnt + 8'd1;
                        end else begin
                            r_state <= c_S_IDLE;
                            f0      <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_cnt   <= 16'd0;
                    f0      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_firefly_queen.sv
// ============================================================================
// Module   : tb_firefly_queen
// Brief    : Randomised self-checking bench for firefly_queen with a
//            period-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_firefly_queen;

    localparam int c_P  = 2000;
    localparam int c_FW = 1000;
    localparam int c_RW = 751;
    localparam int c_TL = 0;
    localparam int c_ML = 2;

    logic        clk = 1'b0;
    logic        rst, en, f1;
    logic        f0, resp_ok, resp_err;
    logic [7:0]  pulse_cnt;
    logic [15:0] last_lat, last_width;

    logic        en_s, f1_s;
    logic        f0_s, ok_s, err_s;
    logic [7:0]  pc_s;
    logic [15:0] lat_s, w_s;

    always #5 clk = ~clk;

    firefly_queen #(.PERIOD(c_P), .FLASH_W(c_FW), .RESP_W(c_RW), .TOL(c_TL), .MAX_LAT(c_ML)) u_dut (
        .clk(clk), .rst(rst), .en(en), .f1(f1), .f0(f0), .resp_ok(resp_ok),
        .resp_err(resp_err), .pulse_cnt(pulse_cnt), .last_lat(last_lat), .last_width(last_width)
    );

    // Short-period instance used for the pulse counter wrap.
    firefly_queen #(.PERIOD(8), .FLASH_W(3), .RESP_W(2), .TOL(0), .MAX_LAT(2)) u_small (
        .clk(clk), .rst(rst), .en(en_s), .f1(f1_s), .f0(f0_s), .resp_ok(ok_s),
        .resp_err(err_s), .pulse_cnt(pc_s), .last_lat(lat_s), .last_width(w_s)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          m_run;
    int          m_ph;
    logic [7:0]  m_pc;
    logic [15:0] m_lat, m_w;
    bit          m_ok, m_err;
    bit          samp [c_P];
    int          lo1, hi1, lo2, hi2;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit pat(input int p);
        return ((p >= lo1) && (p <= hi1)) || ((p >= lo2) && (p <= hi2));
    endfunction

    task automatic set_pat(input int a1, input int b1, input int a2, input int b2);
        lo1 = a1; hi1 = b1; lo2 = a2; hi2 = b2;
        f1 = m_run ? pat(m_ph) : 1'b0;
    endtask

    // Judge a whole recorded period from its f1 samples.
    task automatic evaluate();
        int lat, width, rises;
        bit pass;
        lat = 'hFFFF; width = 0; rises = 0;
        for (int i = 0; i < c_P; i++) begin
            if (samp[i]) begin
                if (lat == 'hFFFF) lat = i;
                width++;
                if (i == 0 || !samp[i-1]) rises++;
            end
        end
        pass = (rises == 1) && !samp[0] && (lat <= c_ML) &&
               (width - c_RW <= c_TL) && (c_RW - width <= c_TL) && !samp[c_P-1];
        m_ok  = pass;
        m_err = !pass;
        m_lat = 16'(lat);
        m_w   = 16'(width);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            m_run = 0; m_ph = 0; m_pc = 8'd0; m_lat = 16'hFFFF; m_w = 16'd0;
            m_ok = 0; m_err = 0;
        end else begin
            m_ok = 0; m_err = 0;
            if (m_run) begin
                samp[m_ph] = f1;
                if (m_ph == c_P - 1) begin
                    evaluate();
                    m_run = 0;
                end else begin
                    m_ph++;
                end
            end
            if (!m_run && en) begin
                m_run = 1; m_ph = 0; m_pc = m_pc + 8'd1;
            end
        end
        chk("f0", {31'd0, f0}, {31'd0, (m_run && m_ph < c_FW)});
        chk("resp_ok", {31'd0, resp_ok}, {31'd0, m_ok});
        chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
        chk("pulse_cnt", {24'd0, pulse_cnt}, {24'd0, m_pc});
        chk("last_lat", {16'd0, last_lat}, {16'd0, m_lat});
        chk("last_width", {16'd0, last_width}, {16'd0, m_w});
        f1 = m_run ? pat(m_ph) : 1'b0;
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (!(m_run && m_ph == target) && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) chk("run_to_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int r, hold;
        rst = 1'b1; en = 1'b0; f1 = 1'b0; en_s = 1'b0; f1_s = 1'b0;
        m_run = 0; m_ph = 0; m_pc = 8'd0; m_lat = 16'hFFFF; m_w = 16'd0;
        set_pat(1, c_RW, -1, -2);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_pc", {24'd0, pulse_cnt}, 32'd0);
        chk("rst_lat", {16'd0, last_lat}, 32'hFFFF);

        // Ideal sentinel: one clean pass, then a seamless second flash.
        en = 1'b1;
        run_to(c_P - 1);
        chk("s1_pc", {24'd0, pulse_cnt}, 32'd1);
        tick();
        chk("s1_ok", {31'd0, resp_ok}, 32'd1);
        chk("s1_lat", {16'd0, last_lat}, 32'd1);
        chk("s1_w", {16'd0, last_width}, 32'd751);
        chk("s1_nogap", {31'd0, f0}, 32'd1);

        // Silent sentinel for two periods.
        set_pat(-1, -2, -1, -2);
        for (int k = 0; k < 2; k++) begin
            run_to(c_P - 1);
            tick();
            chk("s2_err", {31'd0, resp_err}, 32'd1);
            chk("s2_lat", {16'd0, last_lat}, 32'hFFFF);
            chk("s2_w", {16'd0, last_width}, 32'd0);
        end

        set_pat(1, 700, -1, -2);
        run_to(c_P - 1);
        tick();
        chk("s3_err", {31'd0, resp_err}, 32'd1);
        chk("s3_w", {16'd0, last_width}, 32'd700);
        chk("s3_lat", {16'd0, last_lat}, 32'd1);

        set_pat(1, 400, 500, 850);
        run_to(c_P - 1);
        tick();
        chk("s4_double", {31'd0, resp_err}, 32'd1);
        set_pat(0, c_RW, -1, -2);
        run_to(c_P - 1);
        tick();
        chk("s4_starthi", {31'd0, resp_err}, 32'd1);

        // en dropped mid-period: flash and evaluation still complete.
        set_pat(1, c_RW, -1, -2);
        run_to(500);
        en = 1'b0;
        run_to(999);
        chk("s5_f0_999", {31'd0, f0}, 32'd1);
        run_to(c_P - 1);
        tick();
        chk("s5_ok", {31'd0, resp_ok}, 32'd1);
        r = int'(pulse_cnt);
        repeat (50) tick();
        chk("s5_idle_f0", {31'd0, f0}, 32'd0);
        chk("s5_pc_hold", {24'd0, pulse_cnt}, 32'(r));

        // Reset mid-period, with en also high.
        en = 1'b1;
        tick();
        run_to(300);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en = 1'b0;
        chk("s6_f0", {31'd0, f0}, 32'd0);
        chk("s6_pc", {24'd0, pulse_cnt}, 32'd0);
        chk("s6_lat", {16'd0, last_lat}, 32'hFFFF);
        repeat (5) tick();

        // Randomised periods: near-nominal pulses, extra pulses, en drops.
        for (int p = 0; p < 15; p++) begin
            en = 1'b1;
            if (!m_run) tick();
            r = $urandom_range(0, 3);
            hold = r + $urandom_range(c_RW - 2, c_RW + 2) - 1;
            if ($urandom_range(0, 3) == 0) begin
                set_pat(r, hold, 1500, 1500 + $urandom_range(0, 600));
            end else begin
                set_pat(r, hold, -1, -2);
            end
            if ($urandom_range(0, 4) == 0) begin
                run_to($urandom_range(1, c_P - 2));
                en = 1'b0;
            end
            run_to(c_P - 1);
            tick();
            if (!en) repeat ($urandom_range(1, 20)) tick();
        end
        en = 1'b0;

        // Pulse counter wrap on the short-period instance.
        en_s = 1'b1;
        tick();
        chk("wrap_first", {24'd0, pc_s}, 32'd1);
        repeat (8 * 255 - 1) tick();
        chk("wrap_255", {24'd0, pc_s}, 32'd255);
        tick();
        chk("wrap_0", {24'd0, pc_s}, 32'd0);
        chk("wrap_f0", {31'd0, f0_s}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
